// File: rtl/zx_plotter.sv
// ZX-Spectrum screen drawing engine: pixel read-modify-write, attribute writes and
// clear-screen over a single-port video RAM, driven by a valid/ready command port.
module zx_plotter #(
  parameter logic [15:0] BASE    = 16'h4000,
  parameter logic [12:0] CLS_LEN = 13'd6912
) (
  input  logic        clock_25,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [7:0]  cmd_attr,
  input  logic        cmd_attr_we,
  output logic [15:0] address,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in,
  output logic        mem_we,
  input  logic        mem_wait,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // RD    | reading the bitmap byte holding the pixel
  // CAP   | capturing read data and forming the new byte
  // WR    | writing the modified bitmap byte
  // WA    | writing the attribute byte of the pixel's cell
  // CLS   | clearing bitmap then filling attributes
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, WA, CLS} state_t;

  localparam logic [12:0] BITMAP_LEN = 13'd6144;
  localparam logic [15:0] ATTR_BASE  = BASE + 16'h1800;

  function automatic logic [15:0] pix_addr(input logic [7:0] x, input logic [7:0] y);
    return BASE | {3'b000, y[7:6], y[2:0], y[5:3], x[7:3]};
  endfunction

  function automatic logic [15:0] attr_addr(input logic [7:0] x, input logic [7:0] y);
    return ATTR_BASE | {6'b000000, y[7:3], x[7:3]};
  endfunction

  state_t      state, state_nx;
  logic [2:0]  op_q;
  logic [7:0]  x_q, y_q, attr_q;
  logic        attr_we_q;
  logic [12:0] n_q, n_nx, n_inc;
  logic [15:0] addr_nx;
  logic [7:0]  dout_nx, mask, new_byte;
  logic        we_nx, done_nx, err_nx, load_cmd, reject;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign mask      = 8'h80 >> x_q[2:0];
  assign n_inc     = n_q + 13'd1;
  assign reject    = (cmd_op > 3'd4) || ((cmd_op != 3'd4) && (cmd_y > 8'd191));

  always_comb begin
    case (op_q)
      3'd0:    new_byte = data_in | mask;
      3'd1:    new_byte = data_in & ~mask;
      default: new_byte = data_in ^ mask;
    endcase
  end

  always_comb begin
    state_nx = state;
    addr_nx  = address;
    dout_nx  = data_out;
    we_nx    = mem_we;
    n_nx     = n_q;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    load_cmd = 1'b0;
    case (state)
      IDLE: begin
        we_nx = 1'b0;
        if (cmd_valid) begin
          load_cmd = 1'b1;
          if (reject) begin
            err_nx = 1'b1;
          end else if (cmd_op == 3'd3) begin
            state_nx = WA;
            addr_nx  = attr_addr(cmd_x, cmd_y);
            dout_nx  = cmd_attr;
            we_nx    = 1'b1;
          end else if (cmd_op == 3'd4) begin
            state_nx = CLS;
            addr_nx  = BASE;
            dout_nx  = 8'h00;
            we_nx    = 1'b1;
            n_nx     = 13'd0;
          end else begin
            state_nx = RD;
            addr_nx  = pix_addr(cmd_x, cmd_y);
          end
        end
      end
      RD: begin
        if (!mem_wait) state_nx = CAP;
      end
      CAP: begin
        state_nx = WR;
        dout_nx  = new_byte;
        we_nx    = 1'b1;
      end
      WR: begin
        if (!mem_wait) begin
          if (attr_we_q) begin
            state_nx = WA;
            addr_nx  = attr_addr(x_q, y_q);
            dout_nx  = attr_q;
          end else begin
            state_nx = IDLE;
            we_nx    = 1'b0;
            done_nx  = 1'b1;
          end
        end
      end
      WA: begin
        if (!mem_wait) begin
          state_nx = IDLE;
          we_nx    = 1'b0;
          done_nx  = 1'b1;
        end
      end
      CLS: begin
        if (!mem_wait) begin
          if (n_q == CLS_LEN - 13'd1) begin
            state_nx = IDLE;
            n_nx     = 13'd0;
            we_nx    = 1'b0;
            done_nx  = 1'b1;
          end else begin
            n_nx    = n_inc;
            addr_nx = BASE + {3'b000, n_inc};
            dout_nx = (n_inc < BITMAP_LEN) ? 8'h00 : attr_q;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        we_nx    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      address   <= 16'h0000;
      data_out  <= 8'h00;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      n_q       <= 13'd0;
      op_q      <= 3'd0;
      x_q       <= 8'h00;
      y_q       <= 8'h00;
      attr_q    <= 8'h00;
      attr_we_q <= 1'b0;
    end else begin
      state    <= state_nx;
      address  <= addr_nx;
      data_out <= dout_nx;
      mem_we   <= we_nx;
      done     <= done_nx;
      err      <= err_nx;
      n_q      <= n_nx;
      if (load_cmd) begin
        op_q      <= cmd_op;
        x_q       <= cmd_x;
        y_q       <= cmd_y;
        attr_q    <= cmd_attr;
        attr_we_q <= cmd_attr_we;
      end
    end
  end

endmodule

// File: tb/tb_zx_plotter.sv
// Self-checking bench for zx_plotter: directed vector table, stall and reset
// sequences, clear-screen sweeps, and randomized commands against a reference model.
module tb_zx_plotter;

  logic        clock_25 = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_x, cmd_y, cmd_attr;
  logic        cmd_attr_we;
  logic [15:0] address;
  logic [7:0]  data_out;
  logic [7:0]  data_in;
  logic        mem_we;
  logic        mem_wait;
  logic        busy, done, err;

  zx_plotter dut (
    .clock_25(clock_25), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_attr(cmd_attr), .cmd_attr_we(cmd_attr_we),
    .address(address), .data_out(data_out), .data_in(data_in),
    .mem_we(mem_we), .mem_wait(mem_wait),
    .busy(busy), .done(done), .err(err)
  );

  always #20 clock_25 = ~clock_25;

  // memory model with write log
  logic [7:0]  ram [0:65535];
  logic [23:0] wq [$];
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = 16'h0;
  logic [7:0]  poke_data = 8'h0;
  logic        wait_force = 1'b0;
  logic        wait_rand  = 1'b0;
  logic        wait_rnd   = 1'b0;
  int          done_cnt = 0;
  logic        both_seen = 1'b0;

  assign mem_wait = wait_force | wait_rnd;

  always @(negedge clock_25) wait_rnd = wait_rand && ($urandom_range(3) == 0);

  always @(negedge clock_25) begin
    if (done) done_cnt++;
    if (done && err) both_seen = 1'b1;
  end

  always @(posedge clock_25) begin
    if (poke_en) ram[poke_addr] = poke_data;
    if (mem_we && !mem_wait) begin
      ram[address] = data_out;
      wq.push_back({address, data_out});
    end else if (!mem_we && !mem_wait) begin
      data_in <= ram[address];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock_25);
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    @(negedge clock_25);
    poke_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] attr, input logic awe);
    @(negedge clock_25);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_attr = attr; cmd_attr_we = awe;
    @(posedge clock_25);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int limit, output int lat, output logic gd, output logic ge,
                          output logic rdy);
    lat = 0; gd = 1'b0; ge = 1'b0; rdy = 1'b0;
    while (!gd && !ge && lat < limit) begin
      @(negedge clock_25);
      lat++;
      gd = done; ge = err; rdy = cmd_ready;
    end
    if (!gd && !ge) chk("timeout", 32'(lat), 32'(limit + 1));
  endtask

  // reference model, computed arithmetically from screen geometry
  function automatic logic [15:0] m_pix(input int x, input int y);
    return 16'(16'h4000 + (y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + x / 8);
  endfunction
  function automatic logic [15:0] m_attr(input int x, input int y);
    return 16'(16'h5800 + (y / 8) * 32 + x / 8);
  endfunction
  function automatic logic [7:0] m_new(input int op, input int x, input logic [7:0] old);
    logic [7:0] m;
    m = 8'(1 << (7 - (x % 8)));
    if (op == 0) return old | m;
    if (op == 1) return old & ~m;
    return old ^ m;
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  x, y, attr;
    logic        awe, pre_en;
    logic [7:0]  pre;
    int          nw;
    logic [15:0] a0; logic [7:0] d0;
    logic [15:0] a1; logic [7:0] d1;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int lat, base, bad, nexp;
    logic gd, ge, rdy;
    logic [15:0] a_rd, a_wr;
    logic [7:0]  d_wr, old;
    logic [2:0]  oplist [10];
    logic [23:0] exp_w [2];

    //          op    x      y      attr   awe pre pre   nw a0        d0     a1        d1     e  lat
    vecs[0]  = '{3'd0, 8'd0,   8'd0,   8'h00, 0, 1, 8'h00, 1, 16'h4000, 8'h80, 16'h0,    8'h0,  0, 4};
    vecs[1]  = '{3'd2, 8'd9,   8'd8,   8'h00, 0, 1, 8'hFF, 1, 16'h4021, 8'hBF, 16'h0,    8'h0,  0, 4};
    vecs[2]  = '{3'd1, 8'd9,   8'd8,   8'h00, 0, 0, 8'h00, 1, 16'h4021, 8'hBF, 16'h0,    8'h0,  0, 4};
    vecs[3]  = '{3'd0, 8'd255, 8'd191, 8'h47, 1, 1, 8'h00, 2, 16'h57FF, 8'h01, 16'h5AFF, 8'h47, 0, 5};
    vecs[4]  = '{3'd3, 8'd16,  8'd64,  8'h12, 0, 0, 8'h00, 1, 16'h5902, 8'h12, 16'h0,    8'h0,  0, 2};
    vecs[5]  = '{3'd0, 8'd5,   8'd192, 8'h00, 0, 0, 8'h00, 0, 16'h0,    8'h0,  16'h0,    8'h0,  1, 1};
    vecs[6]  = '{3'd6, 8'd5,   8'd10,  8'h00, 0, 0, 8'h00, 0, 16'h0,    8'h0,  16'h0,    8'h0,  1, 1};
    vecs[7]  = '{3'd3, 8'd5,   8'd200, 8'h33, 0, 0, 8'h00, 0, 16'h0,    8'h0,  16'h0,    8'h0,  1, 1};
    vecs[8]  = '{3'd1, 8'd7,   8'd100, 8'h00, 0, 1, 8'hFF, 1, 16'h4C80, 8'hFE, 16'h0,    8'h0,  0, 4};
    vecs[9]  = '{3'd2, 8'd128, 8'd0,   8'h55, 1, 1, 8'h00, 2, 16'h4010, 8'h80, 16'h5810, 8'h55, 0, 5};
    vecs[10] = '{3'd5, 8'd0,   8'd0,   8'h00, 1, 0, 8'h00, 0, 16'h0,    8'h0,  16'h0,    8'h0,  1, 1};
    vecs[11] = '{3'd7, 8'd3,   8'd192, 8'h00, 0, 0, 8'h00, 0, 16'h0,    8'h0,  16'h0,    8'h0,  1, 1};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_x = 8'd0; cmd_y = 8'd0;
    cmd_attr = 8'd0; cmd_attr_we = 1'b0;
    repeat (3) @(negedge clock_25);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].pre_en) poke(vecs[i].a0, vecs[i].pre);
      base = wq.size();
      issue(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].attr, vecs[i].awe);
      wait_end(50, lat, gd, ge, rdy);
      chk($sformatf("v%0d_err", i), 32'(ge), 32'(vecs[i].e));
      chk($sformatf("v%0d_done", i), 32'(gd), 32'(!vecs[i].e));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_ready", i), 32'(rdy), 32'd1);
      repeat (2) @(negedge clock_25);
      chk($sformatf("v%0d_nw", i), 32'(wq.size() - base), 32'(vecs[i].nw));
      if (vecs[i].nw >= 1 && wq.size() > base)
        chk($sformatf("v%0d_w0", i), 32'(wq[base]), 32'({vecs[i].a0, vecs[i].d0}));
      if (vecs[i].nw >= 2 && wq.size() > base + 1)
        chk($sformatf("v%0d_w1", i), 32'(wq[base + 1]), 32'({vecs[i].a1, vecs[i].d1}));
    end

    // stall: three wait cycles in RD and three in WR; RAM[0x4000] holds 0x80
    base = wq.size();
    issue(3'd2, 8'd0, 8'd0, 8'h00, 1'b0);
    lat = 0; gd = 1'b0; bad = 0; a_rd = '0; a_wr = '0; d_wr = '0;
    while (!gd && lat < 40) begin
      @(negedge clock_25);
      lat++;
      if (lat == 1) a_rd = address;
      if (lat >= 2 && lat <= 4 && (address !== a_rd || mem_we !== 1'b0)) bad++;
      if (lat == 6) begin a_wr = address; d_wr = data_out; end
      if (lat >= 6 && lat <= 9 && (address !== a_wr || data_out !== d_wr || mem_we !== 1'b1)) bad++;
      wait_force = ((lat >= 1 && lat <= 3) || (lat >= 6 && lat <= 8));
      gd = done;
    end
    wait_force = 1'b0;
    chk("stall_lat", 32'(lat), 32'd10);
    chk("stall_stable", 32'(bad), 32'd0);
    chk("stall_rd_addr", 32'(a_rd), 32'h4000);
    chk("stall_wr", 32'({a_wr, d_wr}), 32'h400000);
    chk("stall_nw", 32'(wq.size() - base), 32'd1);

    // reset in the middle of a clear
    issue(3'd4, 8'd0, 8'd0, 8'h38, 1'b0);
    lat = 0;
    while (!(address == 16'h4064 && mem_we) && lat < 500) begin
      @(negedge clock_25);
      lat++;
    end
    chk("cls_reach_100", 32'(address), 32'h4064);
    reset_n = 1'b0;
    #1;
    chk("cls_rst_we", 32'(mem_we), 32'd0);
    chk("cls_rst_ready", 32'(cmd_ready), 32'd1);
    chk("cls_rst_busy", 32'(busy), 32'd0);
    @(negedge clock_25);
    reset_n = 1'b1;
    @(negedge clock_25);
    chk("cls_rst_idle", 32'({cmd_ready, mem_we}), 32'h2);

    // full clear with random waits
    wait_rand = 1'b1;
    base = wq.size();
    nexp = done_cnt;
    issue(3'd4, 8'd0, 8'd0, 8'h38, 1'b0);
    wait_end(20000, lat, gd, ge, rdy);
    repeat (3) @(negedge clock_25);
    chk("cls_done_once", 32'(done_cnt - nexp), 32'd1);
    chk("cls_nw", 32'(wq.size() - base), 32'd6912);
    bad = 0;
    for (int k = 0; k < 6912 && base + k < wq.size(); k++)
      if (wq[base + k] !== {16'(16'h4000 + k), (k < 6144) ? 8'h00 : 8'h38}) bad++;
    chk("cls_seq", 32'(bad), 32'd0);

    // randomized commands against the reference model
    oplist = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd7};
    for (int it = 0; it < 60; it++) begin
      int op, x, y;
      logic [7:0] attr;
      logic awe, e;
      op   = int'(oplist[$urandom_range(9)]);
      x    = $urandom_range(255);
      y    = $urandom_range(199);
      attr = 8'($urandom);
      awe  = 1'($urandom);
      e    = (op >= 5) || (op <= 3 && y >= 192);
      nexp = 0;
      if (!e && op <= 2) begin
        old = 8'($urandom);
        poke(m_pix(x, y), old);
        exp_w[0] = {m_pix(x, y), m_new(op, x, old)};
        nexp = 1;
        if (awe) begin exp_w[1] = {m_attr(x, y), attr}; nexp = 2; end
      end else if (!e) begin
        exp_w[0] = {m_attr(x, y), attr};
        nexp = 1;
      end
      base = wq.size();
      issue(3'(op), 8'(x), 8'(y), attr, awe);
      wait_end(200, lat, gd, ge, rdy);
      repeat (2) @(negedge clock_25);
      chk($sformatf("r%0d_outcome", it), 32'({gd, ge}), 32'({!e, e}));
      bad = (wq.size() - base != nexp) ? 1 : 0;
      for (int k = 0; k < nexp && base + k < wq.size(); k++)
        if (wq[base + k] !== exp_w[k]) bad++;
      chk($sformatf("r%0d_writes", it), 32'(bad), 32'd0);
    end
    wait_rand = 1'b0;

    chk("done_err_exclusive", 32'(both_seen), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
